// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the writeback arbiter and its result FIFO.
package wb_arbiter_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;
  // Register 0 reads as zero and is never written.
  localparam int ZERO_REG = 0;

endpackage

// File: rtl/wb_md_fifo.sv
// Synchronous FIFO for mult/div results waiting for a free write-port slot.
// Pushes are ignored while full, pops are ignored while empty; DEPTH must be
// a power of two so the pointers wrap naturally.
module wb_md_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage array: written on accepted push only, no reset needed.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; simultaneous push/pop moves both pointers.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: sole driver of the regfile write port. Pipeline results
// always win; mult/div results wait in a FIFO and drain on any cycle without
// a nonzero pipeline write. A busy scoreboard of pending mult/div
// destinations drives the decode stall.
//
// Handshake md_valid/md_ready: a result is accepted at a rising edge where
// both are high; while md_ready is low the mult/div unit holds md_* stable.
// md_ready depends only on the current FIFO count, so a same-cycle pop does
// not make room.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DATA_W   = wb_arbiter_pkg::DATA_W,
  parameter int REG_AW   = wb_arbiter_pkg::REG_AW,
  parameter int MD_DEPTH = 2
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              md_issue,
  input  logic [REG_AW-1:0] md_issue_reg,
  input  logic              md_valid,
  input  logic [REG_AW-1:0] md_reg,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  input  logic [REG_AW-1:0] id_rs_a,
  input  logic [REG_AW-1:0] id_rs_b,
  input  logic [REG_AW-1:0] id_rd,
  output logic              stall,
  output logic              ctrl_writeEnable,
  output logic [REG_AW-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg
);

  localparam int EW = REG_AW + DATA_W;
  localparam int CW = $clog2(MD_DEPTH + 1);
  localparam logic [REG_AW-1:0] R0 = REG_AW'(ZERO_REG);

  logic [EW-1:0]       head;
  logic [REG_AW-1:0]   head_reg;
  logic [DATA_W-1:0]   head_data;
  logic [CW-1:0]       count;
  logic                full;
  logic                empty;
  logic                pipe_sel;
  logic                fifo_pop;
  logic                push;
  logic                from_fifo;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_set;
  logic [NUM_REGS-1:0] busy_clr;
  logic [NUM_REGS-1:0] busy_next;

  assign md_ready  = (count < CW'(MD_DEPTH));
  assign push      = md_valid & md_ready;
  assign head_reg  = head[DATA_W +: REG_AW];
  assign head_data = head[DATA_W-1:0];
  assign pipe_sel  = wb_valid && (wb_reg != R0);
  assign fifo_pop  = !pipe_sel && !empty;

  wb_md_fifo #(
    .W     (EW),
    .DEPTH (MD_DEPTH)
  ) u_fifo (
    .clock (clock),
    .rst   (ctrl_reset),
    .push  (push),
    .din   ({md_reg, md_data}),
    .pop   (fifo_pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Registered write port: pipeline first, then FIFO head; address/data hold
  // when nothing (or a dropped r0 entry) is selected.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
      from_fifo        <= 1'b0;
    end else if (pipe_sel) begin
      ctrl_writeEnable <= 1'b1;
      ctrl_writeReg    <= wb_reg;
      data_writeReg    <= wb_data;
      from_fifo        <= 1'b0;
    end else if (fifo_pop && (head_reg != R0)) begin
      ctrl_writeEnable <= 1'b1;
      ctrl_writeReg    <= head_reg;
      data_writeReg    <= head_data;
      from_fifo        <= 1'b1;
    end else begin
      ctrl_writeEnable <= 1'b0;
      from_fifo        <= 1'b0;
    end
  end

  // Scoreboard update: clear alongside the FIFO-sourced regfile write, set on
  // issue; set is applied last so it wins on the same register.
  always_comb begin
    busy_set  = '0;
    busy_clr  = '0;
    if (md_issue && (md_issue_reg != R0)) busy_set[md_issue_reg] = 1'b1;
    if (ctrl_writeEnable && from_fifo)    busy_clr[ctrl_writeReg] = 1'b1;
    busy_next = (busy & ~busy_clr) | busy_set;
    busy_next[ZERO_REG] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) busy <= '0;
    else            busy <= busy_next;
  end

  assign stall = busy[id_rs_a] | busy[id_rs_b] | busy[id_rd];

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter: linear sequence of steps, each checked
// against hand-computed values with immediate assertions.
module tb_wb_arbiter;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        md_issue;
  logic [4:0]  md_issue_reg;
  logic        md_valid;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_ready;
  logic [4:0]  id_rs_a;
  logic [4:0]  id_rs_b;
  logic [4:0]  id_rd;
  logic        stall;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] pend = '0;

  wb_arbiter dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .wb_valid         (wb_valid),
    .wb_reg           (wb_reg),
    .wb_data          (wb_data),
    .md_issue         (md_issue),
    .md_issue_reg     (md_issue_reg),
    .md_valid         (md_valid),
    .md_reg           (md_reg),
    .md_data          (md_data),
    .md_ready         (md_ready),
    .id_rs_a          (id_rs_a),
    .id_rs_b          (id_rs_b),
    .id_rd            (id_rd),
    .stall            (stall),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg)
  );

  // Clock
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic we, input logic [4:0] r, input logic [31:0] d);
    check({tag, "_we"}, 64'(ctrl_writeEnable), 64'(we));
    check({tag, "_reg"}, 64'(ctrl_writeReg), 64'(r));
    check({tag, "_data"}, 64'(data_writeReg), 64'(d));
  endtask

  // Protocol monitor: r0 is never written, and mult/div never issues to a
  // register whose result is still pending (the retiring write may coincide).
  always @(negedge clock) begin
    if (ctrl_reset === 1'b1) begin
      pend = '0;
    end else begin
      check("no_r0_write", 64'(ctrl_writeEnable && (ctrl_writeReg == 5'd0)), 64'(0));
      if (md_issue && (md_issue_reg != 5'd0))
        check("issue_not_busy",
              64'(pend[md_issue_reg] && !(ctrl_writeEnable && ctrl_writeReg == md_issue_reg)), 64'(0));
      if (ctrl_writeEnable) pend[ctrl_writeReg] = 1'b0;
      if (md_issue && (md_issue_reg != 5'd0)) pend[md_issue_reg] = 1'b1;
    end
  end

  initial begin
    ctrl_reset = 1'b1;
    wb_valid = 0; wb_reg = 0; wb_data = 0;
    md_issue = 0; md_issue_reg = 0;
    md_valid = 0; md_reg = 0; md_data = 0;
    id_rs_a = 0; id_rs_b = 0; id_rd = 0;

    // Reset state
    tick(); tick();
    check_wr("rst", 1'b0, 5'd0, 32'd0);
    check("rst_ready", 64'(md_ready), 64'(1));
    check("rst_stall", 64'(stall), 64'(0));
    ctrl_reset = 1'b0;
    tick();
    check_wr("idle", 1'b0, 5'd0, 32'd0);

    // Pipeline write to r3, then enable drops with address/data held
    wb_valid = 1; wb_reg = 5'd3; wb_data = 32'hDEADBEEF;
    tick();
    check_wr("wb_n1", 1'b1, 5'd3, 32'hDEADBEEF);
    wb_valid = 0;
    tick();
    check_wr("wb_n2", 1'b0, 5'd3, 32'hDEADBEEF);

    // Mult/div to r7: stall on RAW, write at M+2, stall clears at M+3
    md_issue = 1; md_issue_reg = 5'd7;
    tick();
    md_issue = 0; id_rs_a = 5'd7;
    #1;
    check("md7_stall", 64'(stall), 64'(1));
    md_valid = 1; md_reg = 5'd7; md_data = 32'h1234;
    check("md7_ready", 64'(md_ready), 64'(1));
    tick();
    md_valid = 0;
    check_wr("md7_m1", 1'b0, 5'd3, 32'hDEADBEEF);
    tick();
    check_wr("md7_m2", 1'b1, 5'd7, 32'h1234);
    check("md7_stall_m2", 64'(stall), 64'(1));
    tick();
    check("md7_stall_m3", 64'(stall), 64'(0));
    check("md7_we_m3", 64'(ctrl_writeEnable), 64'(0));
    id_rs_a = 0;

    // Conflict: pipeline owns r4 writes while r8 and r9 queue up
    wb_valid = 1; wb_reg = 5'd4; wb_data = 32'h4444;
    md_issue = 1; md_issue_reg = 5'd8;
    tick();
    md_issue_reg = 5'd9;
    md_valid = 1; md_reg = 5'd8; md_data = 32'h88;
    check("cf_ready0", 64'(md_ready), 64'(1));
    tick();
    check_wr("cf_a2", 1'b1, 5'd4, 32'h4444);
    md_issue = 0;
    md_reg = 5'd9; md_data = 32'h99;
    check("cf_ready1", 64'(md_ready), 64'(1));
    tick();
    md_valid = 0; wb_valid = 0;
    check("cf_full", 64'(md_ready), 64'(0));
    check_wr("cf_a3", 1'b1, 5'd4, 32'h4444);
    id_rd = 5'd9;
    tick();
    check_wr("cf_r8", 1'b1, 5'd8, 32'h88);
    check("cf_ready_after", 64'(md_ready), 64'(1));
    check("cf_stall9_a", 64'(stall), 64'(1));
    tick();
    check_wr("cf_r9", 1'b1, 5'd9, 32'h99);
    check("cf_stall9_b", 64'(stall), 64'(1));
    tick();
    check("cf_done_we", 64'(ctrl_writeEnable), 64'(0));
    check("cf_stall9_c", 64'(stall), 64'(0));
    id_rd = 0;

    // wb_valid to r0 leaves the slot to the queued r6 result
    wb_valid = 1; wb_reg = 5'd1; wb_data = 32'h11;
    md_issue = 1; md_issue_reg = 5'd6;
    tick();
    md_issue = 0;
    md_valid = 1; md_reg = 5'd6; md_data = 32'h66;
    tick();
    md_valid = 0;
    wb_reg = 5'd0; wb_data = 32'h0BAD;
    check_wr("z_b2", 1'b1, 5'd1, 32'h11);
    tick();
    wb_valid = 0;
    check_wr("z_b3", 1'b1, 5'd6, 32'h66);
    tick();
    check_wr("z_b4", 1'b0, 5'd6, 32'h66);

    // Same-cycle clear and set on r10: set wins
    md_issue = 1; md_issue_reg = 5'd10;
    tick();
    md_issue = 0;
    md_valid = 1; md_reg = 5'd10; md_data = 32'hA0;
    tick();
    md_valid = 0; id_rs_b = 5'd10;
    #1;
    check("cs_stall_c2", 64'(stall), 64'(1));
    tick();
    check_wr("cs_c3", 1'b1, 5'd10, 32'hA0);
    md_issue = 1; md_issue_reg = 5'd10;
    check("cs_stall_c3", 64'(stall), 64'(1));
    tick();
    md_issue = 0;
    check("cs_we_c4", 64'(ctrl_writeEnable), 64'(0));
    check("cs_stall_c4", 64'(stall), 64'(1));
    md_valid = 1; md_reg = 5'd10; md_data = 32'hA1;
    tick();
    md_valid = 0;
    tick();
    check_wr("cs_c6", 1'b1, 5'd10, 32'hA1);
    check("cs_stall_c6", 64'(stall), 64'(1));
    tick();
    check("cs_stall_c7", 64'(stall), 64'(0));
    id_rs_b = 0;

    // Reset mid-traffic: two results queued, busy[5] set
    wb_valid = 1; wb_reg = 5'd2; wb_data = 32'h22;
    md_issue = 1; md_issue_reg = 5'd5;
    tick();
    md_issue_reg = 5'd13;
    md_valid = 1; md_reg = 5'd5; md_data = 32'h55;
    tick();
    md_issue = 0;
    md_reg = 5'd13; md_data = 32'h133;
    tick();
    md_valid = 0; wb_valid = 0; id_rs_a = 5'd5;
    #1;
    check("mr_full", 64'(md_ready), 64'(0));
    check("mr_stall", 64'(stall), 64'(1));
    ctrl_reset = 1'b1;
    #1;
    check_wr("mr_async", 1'b0, 5'd0, 32'd0);
    check("mr_async_ready", 64'(md_ready), 64'(1));
    check("mr_async_stall", 64'(stall), 64'(0));
    tick();
    check("mr_edge_we", 64'(ctrl_writeEnable), 64'(0));
    check("mr_edge_ready", 64'(md_ready), 64'(1));
    check("mr_edge_stall", 64'(stall), 64'(0));
    ctrl_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mr_no_write", 64'(ctrl_writeEnable), 64'(0));
      check("mr_no_stall", 64'(stall), 64'(0));
    end
    id_rs_a = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter sitting directly upstream of the register file; it is the only driver of the regfile write port (ctrl_writeEnable, ctrl_writeReg, data_writeReg).
- Merges two result sources: single-cycle pipeline writeback, and a multicycle mult/div unit whose results arrive out of band.
- Holds mult/div results in a small FIFO while the pipeline owns the write port.
- Keeps a busy scoreboard of pending mult/div destinations and raises a decode stall on RAW/WAW hazards.

Parameters:
- DATA_W, 32, data width of results and regfile
- REG_AW, 5, register address width
- MD_DEPTH, 2, mult/div result FIFO depth in entries (power of two, ≥2)

Ports:
- clock  in  1  single clock
- ctrl_reset  in  1  asynchronous, active-high reset
- wb_valid  in  1  pipeline writeback valid; never back-pressured
- wb_reg  in  REG_AW  pipeline destination register
- wb_data  in  DATA_W  pipeline result
- md_issue  in  1  mult/div op issued from decode this cycle
- md_issue_reg  in  REG_AW  destination of the issued mult/div op
- md_valid  in  1  mult/div result valid
- md_reg  in  REG_AW  mult/div result destination
- md_data  in  DATA_W  mult/div result
- md_ready  out  1  FIFO can accept a result
- id_rs_a  in  REG_AW  decode source A
- id_rs_b  in  REG_AW  decode source B
- id_rd  in  REG_AW  decode destination
- stall  out  1  decode must hold
- ctrl_writeEnable  out  1  regfile write enable
- ctrl_writeReg  out  REG_AW  regfile write address
- data_writeReg  out  DATA_W  regfile write data

Behaviour:
- Reset (async, ctrl_reset=1): ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0; FIFO emptied (pointers and count 0); busy vector all 0. Therefore md_ready=1 and stall=0 while in reset. In-flight mult/div results are discarded; the mult/div unit shares the reset.
- Write-port outputs are registered. The selection made in cycle N appears on the outputs in cycle N+1, and the regfile writes at the end of N+1.
- Selection each cycle, at most one write:
  - If wb_valid and wb_reg≠0: select the pipeline.
  - Else, if the FIFO is not empty: pop the head and select it.
  - Else: select nothing, which loads ctrl_writeEnable=0.
  - When nothing is selected, ctrl_writeReg and data_writeReg hold their previous values.
- Register 0 is never written: wb_valid with wb_reg=0 counts as no pipeline write, so the FIFO may use that slot. FIFO entries with reg 0 are popped and dropped (enable 0).
- md_ready = (count < MD_DEPTH), computed from the current count only. A pop in the same cycle does not free space.
- Push occurs when md_valid & md_ready. When not ready, the mult/div unit holds md_* stable.
- Push and pop in the same cycle: count unchanged, and both pointers advance modulo MD_DEPTH.
- Push into an empty FIFO is not bypassed. Minimum mult/div latency: push at edge N → head selected in cycle N+1 → ctrl_writeEnable high in cycle N+2.
- Busy scoreboard, 32 bits:
  - md_issue with md_issue_reg≠0 sets busy[md_issue_reg] at the clock edge.
  - A bit clears at the end of the cycle in which ctrl_writeEnable=1 is driven from a FIFO-sourced write to that register, i.e. together with the regfile write.
  - If a set and a clear hit the same register in the same cycle, the set wins.
  - Bit 0 is always 0.
- stall = busy[id_rs_a] | busy[id_rs_b] | busy[id_rd]. It is combinational from the registered busy vector.
  - Covers RAW on both sources and WAW against a pending mult/div destination.
  - stall drops the cycle after the regfile write.
- Source tag: one internal registered bit marks whether the current output came from the FIFO. It is used only for the busy clear.
- Illegal input: md_issue to an already-busy register. Decode stall prevents it; the bench must assert it never occurs.
- Starvation is acceptable. The FIFO drains on any cycle without a nonzero pipeline write.

Decomposition:
- Shared package holds the constants DATA_W=32, REG_AW=5, NUM_REGS=32 and the zero-register index.
- One natural sub-module, wb_md_fifo: parameterised synchronous FIFO with count, push/pop, full/empty, and async active-high reset.
- The scoreboard and the output register stay in wb_arbiter.

Test Plan:
- Reset pulse mid-traffic (FIFO holding 2 entries, busy[5]=1) → next edge ctrl_writeEnable=0, md_ready=1, stall=0, and no write to r5 follows.
- wb_valid=1, wb_reg=3, wb_data=0xDEADBEEF in cycle N → cycle N+1: ctrl_writeEnable=1, ctrl_writeReg=3, data_writeReg=0xDEADBEEF; cycle N+2: enable 0.
- md_issue reg 7 in cycle N; id_rs_a=7 from N+1 → stall=1. md_valid reg 7, data 0x1234 at cycle M with no wb traffic → enable=1 with reg 7 in cycle M+2; stall=0 in cycle M+3.
- Conflict case: wb_valid continuously to reg 4 while two md results arrive (regs 8 and 9) → both queued, md_ready=0 when the FIFO is full. After wb_valid drops, writes go to r8 then r9 on consecutive cycles, in order.
- wb_valid with wb_reg=0 while the FIFO holds reg 6 → FIFO entry written that cycle's slot (r6 enable next cycle), and r0 is never enabled.
- Same-cycle clear/set: FIFO write to r10 output cycle coincides with md_issue reg 10 → busy[10] remains 1, and stall stays high for id_rs_b=10.
